// File: rtl/avr_bus_master.sv
// AVR-side initiator for the AVR<->CPLD control interface.
// Converts LOAD/READ/WRITE/INC commands into CPLD pin waveforms.
//
// Ports:
//   avr_clk, avr_reset        clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op                    00 LOAD, 01 READ, 10 WRITE, 11 INC
//   cmd_addr, cmd_wdata       LOAD address / WRITE data, latched at accept
//   rsp_valid, rsp_rdata      one-cycle read pulse, last read byte
//   cur_addr                  shadow of the CPLD address counter
//   avr_si, avr_sreg_en_n     serial address bit, shift enable (low)
//   avr_oe_n, avr_we_n        read / write strobes (low)
//   avr_counter_n             address increment strobe (low)
//   avr_data                  bidirectional data, driven only for WRITE
module avr_bus_master #(
  parameter int ADDR_BITS     = 21,
  parameter int SHIFT_HOLD    = 2,
  parameter int ACCESS_CYCLES = 5,
  parameter int INC_CYCLES    = 2
) (
  input  logic                 avr_clk,
  input  logic                 avr_reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [7:0]           cmd_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic [ADDR_BITS-1:0] cur_addr,
  output logic                 avr_si,
  output logic                 avr_sreg_en_n,
  output logic                 avr_oe_n,
  output logic                 avr_we_n,
  output logic                 avr_counter_n,
  inout  wire  [7:0]           avr_data
);

  localparam int BW = $clog2(ADDR_BITS + 1);
  localparam logic [7:0] SH_LAST  = 8'(SHIFT_HOLD - 1);
  localparam logic [7:0] ACC_LAST = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] INC_LAST = 8'(INC_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, SHIFT, SHIFT_END, RD, RD_DONE,
    WR, WR_HOLD, INC_LO, INC_HI
  } state_t;

  state_t                 state_q;
  logic [7:0]             cnt_q;
  logic [BW-1:0]          bit_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [7:0]             wdata_q;
  logic                   drive_q;
  logic                   rsp_valid_q;
  logic [7:0]             rdata_q;
  logic [ADDR_BITS-1:0]   cur_q;
  logic                   si_q;
  logic                   en_n_q;
  logic                   oe_n_q;
  logic                   we_n_q;
  logic                   cnt_n_q;

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign cur_addr      = cur_q;
  assign avr_si        = si_q;
  assign avr_sreg_en_n = en_n_q;
  assign avr_oe_n      = oe_n_q;
  assign avr_we_n      = we_n_q;
  assign avr_counter_n = cnt_n_q;
  assign avr_data      = drive_q ? wdata_q : 8'hzz;

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      cur_q       <= '0;
      si_q        <= 1'b0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cnt_n_q     <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cnt_q <= '0;
            unique case (cmd_op)
              2'b00: begin
                state_q <= SHIFT;
                addr_q  <= cmd_addr;
                bit_q   <= BW'(ADDR_BITS - 1);
                si_q    <= cmd_addr[ADDR_BITS-1];
                en_n_q  <= 1'b0;
              end
              2'b01: begin
                state_q <= RD;
                oe_n_q  <= 1'b0;
              end
              2'b10: begin
                state_q <= WR;
                wdata_q <= cmd_wdata;
                drive_q <= 1'b1;
                we_n_q  <= 1'b0;
              end
              default: begin
                state_q <= INC_LO;
                cnt_n_q <= 1'b0;
              end
            endcase
          end
        end
        SHIFT: begin
          if (cnt_q == SH_LAST) begin
            cnt_q <= '0;
            if (bit_q == '0) begin
              state_q <= SHIFT_END;
              si_q    <= 1'b0;
            end else begin
              bit_q <= bit_q - 1'b1;
              si_q  <= addr_q[bit_q - 1'b1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHIFT_END: begin
          state_q <= IDLE;
          en_n_q  <= 1'b1;
          cur_q   <= addr_q;
        end
        RD: begin
          if (cnt_q == ACC_LAST) begin
            state_q     <= RD_DONE;
            rdata_q     <= avr_data;
            oe_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RD_DONE: state_q <= IDLE;
        WR: begin
          if (cnt_q == ACC_LAST) begin
            state_q <= WR_HOLD;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WR_HOLD: begin
          state_q <= IDLE;
          drive_q <= 1'b0;
        end
        INC_LO: begin
          if (cnt_q == INC_LAST) begin
            state_q <= INC_HI;
            cnt_q   <= '0;
            cnt_n_q <= 1'b1;
            cur_q   <= cur_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        INC_HI: begin
          if (cnt_q == INC_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_bus_master.sv
// Directed and random-stream bench for avr_bus_master.
// Samples 1 time unit after each rising edge.
module tb_avr_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [20:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [20:0] cur_addr;
  logic        avr_si, en_n, oe_n, we_n, cnt_n;
  wire  [7:0]  avr_data;
  logic        tb_en;
  logic [7:0]  tb_drv;

  int checks = 0;
  int failures = 0;

  assign avr_data = tb_en ? tb_drv : 8'hzz;

  always #5 clk = ~clk;

  avr_bus_master dut (
    .avr_clk(clk), .avr_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cur_addr(cur_addr), .avr_si(avr_si),
    .avr_sreg_en_n(en_n), .avr_oe_n(oe_n),
    .avr_we_n(we_n), .avr_counter_n(cnt_n),
    .avr_data(avr_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [20:0] a,
                       input logic [7:0] d);
    int w = 0;
    while (!cmd_ready && w < 200) begin
      step();
      w++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL issue_ready got=%b want=1", cmd_ready);
    end
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_addr = 21'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    got = {avr_si, en_n, oe_n, we_n, cnt_n, cmd_ready,
           rsp_valid, rsp_rdata};
    checks++;
    if (got !== 15'b0_1111_1_0_00000000) begin
      failures++;
      $display("FAIL reset_outs got=%b want=%b", got,
               15'b0_1111_1_0_00000000);
    end
    checks++;
    if (cur_addr !== 21'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h want=0", cur_addr);
    end
  endtask

  task automatic test_load();
    logic [20:0] a;
    logic        exp_si;
    int          bad;
    a = 21'h004CCF;
    issue(2'b00, a, 8'h00);
    bad = 0;
    for (int k = 0; k < 43; k++) begin
      exp_si = (k < 42) ? a[20 - k / 2] : 1'b0;
      checks++;
      if (en_n !== 1'b0 || avr_si !== exp_si || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL load_cyc%0d en_n=%b si=%b rdy=%b want 0 %b 0",
                 k, en_n, avr_si, cmd_ready, exp_si);
      end
      step();
    end
    checks++;
    if (en_n !== 1'b1 || cmd_ready !== 1'b1 || cur_addr !== a) begin
      failures++;
      $display("FAIL load_end en_n=%b rdy=%b addr=%h want 1 1 %h",
               en_n, cmd_ready, cur_addr, a);
    end
  endtask

  task automatic test_read(input logic [7:0] v);
    tb_en = 1'b1;
    tb_drv = v;
    issue(2'b01, 21'h0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (oe_n !== 1'b0 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL read_cyc%0d oe_n=%b rv=%b want 0 0",
                 k, oe_n, rsp_valid);
      end
      step();
    end
    tb_drv = 8'h00;
    checks++;
    if (oe_n !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== v) begin
      failures++;
      $display("FAIL read_done oe_n=%b rv=%b data=%h want 1 1 %h",
               oe_n, rsp_valid, rsp_rdata, v);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_rdata !== v) begin
      failures++;
      $display("FAIL read_idle rv=%b rdy=%b data=%h want 0 1 %h",
               rsp_valid, cmd_ready, rsp_rdata, v);
    end
    tb_en = 1'b0;
  endtask

  task automatic test_write();
    tb_en = 1'b0;
    issue(2'b10, 21'h0, 8'hEE);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (we_n !== (k == 5) || oe_n !== 1'b1 || avr_data !== 8'hEE) begin
        failures++;
        $display("FAIL write_cyc%0d we_n=%b oe_n=%b data=%h want %b 1 ee",
                 k, we_n, oe_n, avr_data, k == 5);
      end
      if (k == 5) begin
        tb_en = 1'b1;
        tb_drv = 8'h5A;
      end
      step();
    end
    checks++;
    if (avr_data !== 8'h5A || cmd_ready !== 1'b1 || we_n !== 1'b1) begin
      failures++;
      $display("FAIL write_release data=%h rdy=%b we_n=%b want 5a 1 1",
               avr_data, cmd_ready, we_n);
    end
    tb_en = 1'b0;
  endtask

  task automatic test_inc_wrap();
    issue(2'b00, 21'h1FFFFF, 8'h00);
    issue(2'b11, 21'h0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt_n !== (k >= 2) || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL inc_cyc%0d cnt_n=%b rdy=%b want %b 0",
                 k, cnt_n, cmd_ready, k >= 2);
      end
      step();
    end
    checks++;
    if (cur_addr !== 21'h0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL inc_wrap addr=%h rdy=%b want 000000 1",
               cur_addr, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int at[3];
    cmd_op = 2'b11;
    cmd_valid = 1'b1;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      if (cmd_ready) begin
        at[acc] = c;
        acc++;
      end
      step();
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (acc != 3 || at[1] - at[0] != 5 || at[2] - at[1] != 5) begin
      failures++;
      $display("FAIL b2b_timing acc=%0d gaps=%0d,%0d want 3 5,5",
               acc, at[1] - at[0], at[2] - at[1]);
    end
    checks++;
    if (cur_addr !== 21'h3 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_addr addr=%h rdy=%b want 000003 1",
               cur_addr, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    issue(2'b00, 21'h155555, 8'h00);
    for (int k = 1; k < 10; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (en_n !== 1'b1 || avr_si !== 1'b0 || cur_addr !== 21'h0 ||
        cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid en_n=%b si=%b addr=%h rdy=%b rv=%b want 1 0 0 1 0",
               en_n, avr_si, cur_addr, cmd_ready, rsp_valid);
    end
    test_read(8'h22);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [20:0] a;
    logic [7:0]  d;
    logic [20:0] m_addr;
    logic [7:0]  m_rdata;
    int          busy, cyc, pulses, lows, bad;
    m_addr = cur_addr;
    m_rdata = rsp_rdata;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      op = 2'($urandom_range(0, 3));
      a = 21'($urandom);
      d = 8'($urandom);
      tb_en = (op != 2'b10);
      tb_drv = 8'($urandom);
      issue(op, a, d);
      cyc = 0;
      pulses = 0;
      while (!cmd_ready && cyc < 100) begin
        lows = int'(!en_n) + int'(!oe_n) + int'(!we_n) + int'(!cnt_n);
        if (lows > 1 || (!oe_n && avr_data !== tb_drv)) bad++;
        if (rsp_valid) pulses++;
        step();
        cyc++;
      end
      unique case (op)
        2'b00: begin busy = 43; m_addr = a; end
        2'b01: begin busy = 6; m_rdata = tb_drv; end
        2'b10: busy = 6;
        default: begin busy = 4; m_addr = m_addr + 21'h1; end
      endcase
      checks++;
      if (cyc != busy || pulses != int'(op == 2'b01) ||
          cur_addr !== m_addr || rsp_rdata !== m_rdata ||
          {en_n, oe_n, we_n, cnt_n} !== 4'hF) begin
        failures++;
        $display("FAIL rand%0d op=%0d busy=%0d/%0d pulses=%0d addr=%h/%h rd=%h/%h",
                 n, op, cyc, busy, pulses, cur_addr, m_addr,
                 rsp_rdata, m_rdata);
      end
    end
    tb_en = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rand_strobes violations=%0d want 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = '0;
    cmd_wdata = '0;
    tb_en = 1'b0;
    tb_drv = '0;
    test_reset();
    test_load();
    test_read(8'hAA);
    test_read(8'hBB);
    test_write();
    test_inc_wrap();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avr_bus_master.md
Name: avr_bus_master

Overview:
- Host-side initiator for the AVR↔CPLD control interface, acting as the AVR end of the protocol.
- Turns word-level commands (load address, read, write, increment) into the pin-level waveform the CPLD expects:
  - serial address shift via avr_si / avr_sreg_en_n
  - avr_oe_n / avr_we_n strobes
  - avr_counter_n pulses
  - tri-state avr_data
- Used by the system-level bench and by the host-emulation build to drive the system top automatically.

Parameters:
- ADDR_BITS, 21, width of the SRAM address shifted into the CPLD shift register.
- SHIFT_HOLD, 2, clock cycles each serial address bit is held on avr_si.
- ACCESS_CYCLES, 5, clock cycles avr_oe_n or avr_we_n is held low per access (min 2).
- INC_CYCLES, 2, cycles avr_counter_n is held low, then the same number held high, per increment.

Ports:
- avr_clk  input  1  system clock; all logic on rising edge.
- avr_reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; command accepted on edge with cmd_valid && cmd_ready.
- cmd_op  input  2  00 LOAD, 01 READ, 10 WRITE, 11 INC.
- cmd_addr  input  ADDR_BITS  address for LOAD.
- cmd_wdata  input  8  data for WRITE.
- rsp_valid  output  1  one-cycle pulse: READ data available.
- rsp_rdata  output  8  last read byte; holds until next READ completes.
- cur_addr  output  ADDR_BITS  shadow of CPLD address counter.
- avr_si  output  1  serial address bit.
- avr_sreg_en_n  output  1  shift-register enable, active low.
- avr_oe_n  output  1  read strobe, active low.
- avr_we_n  output  1  write strobe, active low.
- avr_counter_n  output  1  address-counter increment strobe, active low.
- avr_data  inout  8  data bus; driven only during WRITE, otherwise 8'hzz.

Behaviour:
- Reset, and idle values:
  - avr_si=0, avr_sreg_en_n=1, avr_oe_n=1, avr_we_n=1, avr_counter_n=1, avr_data=zz.
  - cmd_ready=1, rsp_valid=0, rsp_rdata=00, cur_addr=0.
  - State IDLE.
- Reset asserted mid-operation:
  - Outputs return to idle values at the same edge; the command is aborted.
  - No rsp_valid; cur_addr clears to 0.
- Inputs sampled only at acceptance. cmd_addr/cmd_wdata are latched internally; later changes are ignored.
- States: IDLE, SHIFT, SHIFT_END, RD, RD_DONE, WR, WR_HOLD, INC_LO, INC_HI.
- LOAD:
  - SHIFT: avr_sreg_en_n=0; address sent MSB first (bit ADDR_BITS-1 first); each bit on avr_si for SHIFT_HOLD cycles.
  - Then SHIFT_END for 1 cycle: en_n still 0, avr_si=0.
  - Then IDLE with en_n=1.
  - Busy ADDR_BITS*SHIFT_HOLD+1 cycles (default 43).
  - cur_addr updates to cmd_addr on the SHIFT_END→IDLE edge.
- READ:
  - RD: avr_oe_n=0 for ACCESS_CYCLES cycles; avr_data sampled into rsp_rdata on the edge ending the last RD cycle.
  - RD_DONE for 1 cycle: oe_n=1, rsp_valid=1. Then IDLE.
  - Busy ACCESS_CYCLES+1.
- WRITE:
  - WR: avr_we_n=0 and avr_data=cmd_wdata for ACCESS_CYCLES cycles.
  - WR_HOLD for 1 cycle: we_n=1, data still driven (hold time).
  - Then IDLE, bus released to zz.
  - Busy ACCESS_CYCLES+1.
- INC:
  - INC_LO: avr_counter_n=0 for INC_CYCLES cycles.
  - INC_HI: counter_n=1 for INC_CYCLES cycles. Then IDLE.
  - cur_addr increments on the INC_LO→INC_HI edge and wraps from 2^ADDR_BITS-1 to 0.
- Strobe exclusivity: at most one of sreg_en_n/oe_n/we_n/counter_n is low in any cycle. All are high for at least one cycle between commands (the IDLE acceptance cycle).
- avr_data is never driven while avr_oe_n=0.
- Back-to-back commands: cmd_valid held high is accepted in the first IDLE cycle. Throughput is one command per (busy+1) cycles.
- rsp_valid is never asserted outside RD_DONE. rsp_rdata is unchanged by LOAD/WRITE/INC.
- Counters are sized for the parameter maxima; no overflow at defaults.

Test Plan:
- Reset then LOAD cmd_addr=21'h004CCF:
  - avr_si shows bits 20..0 MSB first, 2 cycles each, with en_n low for 43 cycles.
  - cur_addr=004CCF afterwards; cmd_ready back high.
- READ with the bench driving avr_data=8'hAA:
  - oe_n low exactly 5 cycles; rsp_valid one cycle with rsp_rdata=AA.
  - A second READ with 8'hBB gives BB.
- WRITE cmd_wdata=8'hEE:
  - we_n low 5 cycles with avr_data=EE, data held 1 further cycle with we_n high, then zz.
  - oe_n stays 1 throughout.
- INC from cur_addr=1FFFFF:
  - counter_n low 2 cycles then high 2 cycles; cur_addr wraps to 000000.
  - Three back-to-back INCs from 0 give cur_addr=3.
- avr_reset asserted in cycle 10 of a LOAD:
  - Next edge: en_n=1, avr_si=0, cur_addr=0, cmd_ready=1, no rsp_valid.
  - A following READ of 8'h22 completes normally.
- Random command stream (1000 commands) checked against a reference model:
  - Strobe exclusivity, no avr_data drive during oe_n low, cycle-exact busy lengths.
